// File: rtl/fifo2stream_pkg.sv
// rtl/fifo2stream_pkg.sv - shared word/pixel layout helpers for the pixel packer and fifo2stream
package fifo2stream_pkg;

    localparam int TDATA_OFS = 0;

    typedef enum logic {
        SYNC_SEARCH = 1'b0,
        SYNC_RUN    = 1'b1
    } sync_state_t;

    // Each pixel slot is {tlast, tuser, tdata}.
    function automatic int slot_width(input int pixel_width);
        return pixel_width + 2;
    endfunction

    function automatic int word_width(input int ddp, input int pixel_width);
        return ddp * (pixel_width + 2);
    endfunction

    function automatic int tuser_ofs(input int pixel_width);
        return pixel_width;
    endfunction

    function automatic int tlast_ofs(input int pixel_width);
        return pixel_width + 1;
    endfunction

    function automatic int logb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/fifo2stream_if.sv
// rtl/fifo2stream_if.sv - AXI4-Stream pixel interface with master/slave modports
interface fifo2stream_if #(
    parameter int C_PIXEL_WIDTH = 8
);
    logic                     tvalid;
    logic [C_PIXEL_WIDTH-1:0] tdata;
    logic                     tuser;
    logic                     tlast;
    logic                     tready;

    modport master (output tvalid, tdata, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/fifo2stream_wordbuf.sv
// rtl/fifo2stream_wordbuf.sv - two-entry word buffer issuing FIFO pops, at most two words owned
module fifo2stream_wordbuf
    import fifo2stream_pkg::*;
#(
    parameter int C_WORD_WIDTH = word_width(4, 8)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    empty,
    input  logic [C_WORD_WIDTH-1:0] rd_data,
    output logic                    rd_en,
    input  logic                    word_done,
    output logic                    head_valid,
    output logic [C_WORD_WIDTH-1:0] head_data
);

    logic                    next_valid;
    logic [C_WORD_WIDTH-1:0] next_data;
    logic                    rd_pending;
    logic [1:0]              occ;
    logic                    head_free;

    assign occ       = {1'b0, head_valid} + {1'b0, next_valid} + {1'b0, rd_pending};
    assign rd_en     = resetn & ~empty & ((occ < 2'd2) | word_done);
    // Head is free after this edge if it is consumed with nothing behind it, or was never filled.
    assign head_free = word_done ? ~next_valid : ~head_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_valid <= 1'b0;
            head_data  <= '0;
            next_valid <= 1'b0;
            next_data  <= '0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= rd_en;
            if (word_done) begin
                head_valid <= next_valid;
                head_data  <= next_data;
                next_valid <= 1'b0;
            end
            if (rd_pending) begin
                if (head_free) begin
                    head_valid <= 1'b1;
                    head_data  <= rd_data;
                end else begin
                    next_valid <= 1'b1;
                    next_data  <= rd_data;
                end
            end
        end
    end

endmodule

// File: rtl/fifo2stream.sv
// rtl/fifo2stream.sv - unpacks FIFO words into AXI4-Stream pixels; FIFO2STREAM_SOF_SYNC_EN adds start-of-frame search
module fifo2stream
    import fifo2stream_pkg::*;
#(
    parameter int  C_PIXEL_WIDTH = 8,
    parameter int  C_DATA_WIDTH  = 32,
    localparam int C_DDP         = C_DATA_WIDTH / C_PIXEL_WIDTH,
    localparam int WORD_W        = word_width(C_DDP, C_PIXEL_WIDTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              empty,
    input  logic [WORD_W-1:0] rd_data,
    output logic              rd_en,
    fifo2stream_if.master     m_axis
);

    localparam int SLOT_W  = slot_width(C_PIXEL_WIDTH);
    localparam int PIDX_W  = (logb2(C_DDP) > 0) ? logb2(C_DDP) : 1;
    localparam int TUSER_B = tuser_ofs(C_PIXEL_WIDTH);
    localparam int TLAST_B = tlast_ofs(C_PIXEL_WIDTH);

    logic              head_valid;
    logic [WORD_W-1:0] head_data;
    logic [PIDX_W-1:0] pidx;
    logic [SLOT_W-1:0] cur;
    logic              advance;
    logic              word_done;

    fifo2stream_wordbuf #(.C_WORD_WIDTH(WORD_W)) u_wordbuf (
        .clk        (clk),
        .resetn     (resetn),
        .empty      (empty),
        .rd_data    (rd_data),
        .rd_en      (rd_en),
        .word_done  (word_done),
        .head_valid (head_valid),
        .head_data  (head_data)
    );

    always_comb begin
        cur = '0;
        for (int i = 0; i < C_DDP; i++) begin
            if (pidx == PIDX_W'(i)) cur = head_data[SLOT_W*i +: SLOT_W];
        end
    end

    assign m_axis.tdata = cur[TDATA_OFS +: C_PIXEL_WIDTH];
    assign m_axis.tuser = cur[TUSER_B];
    assign m_axis.tlast = cur[TLAST_B];

`ifdef FIFO2STREAM_SOF_SYNC_EN
    sync_state_t state;
    logic        show;

    // While searching, pixels without tuser are dropped one per clock without a handshake.
    assign show          = (state == SYNC_RUN) | cur[TUSER_B];
    assign m_axis.tvalid = head_valid & show;
    assign advance       = head_valid & (show ? m_axis.tready : 1'b1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= SYNC_SEARCH;
        end else if (state == SYNC_SEARCH && head_valid && cur[TUSER_B]) begin
            state <= SYNC_RUN;
        end
    end
`else
    assign m_axis.tvalid = head_valid;
    assign advance       = head_valid & m_axis.tready;
`endif

    assign word_done = advance & (pidx == PIDX_W'(C_DDP - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pidx <= '0;
        end else if (advance) begin
            pidx <= word_done ? '0 : pidx + PIDX_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo2stream.sv
// tb/tb_fifo2stream.sv - randomized self-checking bench for fifo2stream against a queue-based pixel model
module tb_fifo2stream;

    localparam int PW  = 8;
    localparam int DW  = 32;
    localparam int DDP = DW / PW;
    localparam int SW  = PW + 2;
    localparam int WW  = DDP * SW;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          empty  = 1'b1;
    logic [WW-1:0] rd_data = '0;
    logic          rd_en;

    fifo2stream_if #(.C_PIXEL_WIDTH(PW)) m_axis ();

    fifo2stream #(.C_PIXEL_WIDTH(PW), .C_DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .empty   (empty),
        .rd_data (rd_data),
        .rd_en   (rd_en),
        .m_axis  (m_axis)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [WW-1:0] fifo_q[$];
    logic [SW-1:0] exp_q[$];
    int  errors = 0;
    int  checks = 0;
    bit  pop_req = 1'b0;
    int  pops = 0;
    int  hs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int i = 0; i < DDP; i++) begin
            w[SW*i +: SW] = {($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 8'($urandom)};
        end
        return w;
    endfunction

    // FIFO model: pop decided at the falling edge, data valid the cycle after the pop.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pop_req && fifo_q.size() > 0) rd_data = fifo_q.pop_front();
            empty = (fifo_q.size() == 0);
        end
    end

    // Reference model and per-cycle compare.
    initial begin
        logic [SW-1:0] cur_pix, prev_pix;
        bit hs_now, prev_stall;
        prev_stall = 1'b0;
        prev_pix   = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pop_req    = 1'b0;
                prev_stall = 1'b0;
            end else begin
                cur_pix = {m_axis.tlast, m_axis.tuser, m_axis.tdata};
                hs_now  = m_axis.tvalid & m_axis.tready;
                if (prev_stall) check("stall_hold", {m_axis.tvalid, cur_pix}, {1'b1, prev_pix});
                if (m_axis.tvalid) begin
                    if (exp_q.size() == 0) begin
                        check("garbage_pixel", cur_pix, 'x);
                    end else begin
                        check("pixel", cur_pix, exp_q[0]);
                        if (hs_now) void'(exp_q.pop_front());
                    end
                end
                if (rd_en) begin
                    check("pop_when_empty", empty, 0);
                    check("owned_le2", 64'((pops + 1 - (hs + int'(hs_now)) / DDP) <= 2), 1);
                    if (fifo_q.size() > 0) begin
                        for (int i = 0; i < DDP; i++) exp_q.push_back(fifo_q[0][SW*i +: SW]);
                    end
                    pops++;
                end
                pop_req = rd_en & ~empty;
                if (hs_now) hs++;
                prev_stall = m_axis.tvalid & ~m_axis.tready;
                prev_pix   = cur_pix;
            end
        end
    end

    task automatic wait_tvalid(input string name);
        int n = 0;
        while (!m_axis.tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!m_axis.tvalid) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        m_axis.tready = 1'b1;
        @(negedge clk);
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || m_axis.tvalid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0]    lit[4];
        logic [WW-1:0] w;
        int t_rd, t_v, n, run, tl_idx, tl_cnt;

        m_axis.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_axis.tvalid, 0);
        check("rst_tdata",  m_axis.tdata,  0);
        check("rst_tuser",  m_axis.tuser,  0);
        check("rst_tlast",  m_axis.tlast,  0);
        check("rst_rd_en",  rd_en,         0);
        resetn = 1'b1;
        m_axis.tready = 1'b1;

        // Single word {0x11,0x22,0x33,0x44}, tuser on pixel 0.
        lit = '{8'h11, 8'h22, 8'h33, 8'h44};
        fifo_q.push_back({2'b00, 8'h44, 2'b00, 8'h33, 2'b00, 8'h22, 2'b01, 8'h11});
        n = 0;
        @(negedge clk);
        while (!rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        t_rd = cyc;
        wait_tvalid("first_word");
        t_v = cyc;
        check("latency_rd_to_tvalid", t_v - t_rd, 2);
        for (int k = 0; k < 4; k++) begin
            check("word1_tvalid", m_axis.tvalid, 1);
            check("word1_tdata",  m_axis.tdata,  lit[k]);
            check("word1_tuser",  m_axis.tuser,  (k == 0));
            @(negedge clk);
        end
        check("word1_underflow", m_axis.tvalid, 0);

        // Eight queued words must stream gap-free.
        wait_idle();
        for (int i = 0; i < 8; i++) fifo_q.push_back(rand_word());
        wait_tvalid("burst");
        run = 0;
        for (int i = 0; i < 32; i++) begin
            if (m_axis.tvalid) run++;
            @(negedge clk);
        end
        check("burst_continuous", run, 32);
        check("burst_underflow", m_axis.tvalid, 0);

        // Alternating tready, then random tready with sporadic FIFO refills.
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            m_axis.tready = cyc[0];
            if ($urandom_range(0, 5) == 0) fifo_q.push_back(rand_word());
        end
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            m_axis.tready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 4) == 0) fifo_q.push_back(rand_word());
        end

        // tlast on pixel 2 of the third word lands on overall pixel 10.
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            w = '0;
            for (int p = 0; p < DDP; p++) w[SW*p +: SW] = {2'b00, 8'(16 * i + p)};
            if (i == 2) w[SW*2 + PW + 1] = 1'b1;
            fifo_q.push_back(w);
        end
        n = 0;
        tl_idx = -1;
        tl_cnt = 0;
        for (int i = 0; i < 100 && n < 16; i++) begin
            @(negedge clk);
            if (m_axis.tvalid && m_axis.tready) begin
                if (m_axis.tlast) begin
                    tl_idx = n;
                    tl_cnt++;
                end
                n++;
            end
        end
        check("tlast_index", 64'(tl_idx), 10);
        check("tlast_count", tl_cnt, 1);

        // Reset mid-word with a read in flight.
        wait_idle();
        fifo_q.push_back({4{2'b00, 8'h3C}});
        wait_tvalid("pre_reset");
        @(negedge clk);
        fifo_q.push_back({4{2'b00, 8'h5A}});
        fifo_q.push_back({2'b00, 8'hD4, 2'b00, 8'hC3, 2'b00, 8'hB2, 2'b01, 8'hA5});
        n = 0;
        @(negedge clk);
        while (!rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_pop", rd_en, 1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_tvalid", m_axis.tvalid, 0);
        check("mid_rst_tdata",  m_axis.tdata,  0);
        check("mid_rst_tuser",  m_axis.tuser,  0);
        check("mid_rst_tlast",  m_axis.tlast,  0);
        check("mid_rst_rd_en",  rd_en,         0);
        exp_q.delete();
        pops = 0;
        hs = 0;
        resetn = 1'b1;
        @(negedge clk);
        wait_tvalid("post_reset");
        check("post_reset_tdata", m_axis.tdata, 8'hA5);
        check("post_reset_tuser", m_axis.tuser, 1);

        wait_idle();
        check("fifo_drained", fifo_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fifo2stream.md
# fifo2stream

Read-side counterpart of the pixel packer: pops packed words from a standard (non-FWFT) FIFO and unpacks each into C_DATA_WIDTH/C_PIXEL_WIDTH pixels on an AXI4-Stream master, restoring per-pixel tuser/tlast. It sits directly after the FIFO, typically across a clock-domain or burst boundary. Sustains one pixel per clock under continuous tready.

## Interface
- C_PIXEL_WIDTH, 8, bits per pixel
- C_DATA_WIDTH, 32, packed payload bits per word; C_DDP = C_DATA_WIDTH/C_PIXEL_WIDTH, 1..16
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low; clock clk
- empty  in  1  FIFO empty
- rd_data  in  C_DDP*(C_PIXEL_WIDTH+2)  FIFO read data, valid the cycle after rd_en
- rd_en  out  1  FIFO pop request
- m_axis_tvalid  out  1  pixel valid
- m_axis_tdata  out  C_PIXEL_WIDTH  pixel
- m_axis_tuser  out  1  start of frame
- m_axis_tlast  out  1  end of line
- m_axis_tready  in  1  downstream ready

## Operation
- Word layout: pixel i = rd_data[(C_PIXEL_WIDTH+2)*i +: C_PIXEL_WIDTH+2] = {tlast, tuser, tdata}; pixel 0 is oldest, emitted first, pixel C_DDP-1 last.
- Two-entry word buffer (head, next) plus rd_pending flag (read issued, data arriving next cycle). occ = entries + rd_pending, 0..2.
- word_done = m_axis_tvalid & m_axis_tready & (pidx == C_DDP-1).
- rd_en = resetn & ~empty & (occ < 2 | word_done). Never popped when empty; never more than 2 words owned.
- rd_data captured into the first free slot when rd_pending; on word_done head is freed, next moves to head in the same edge.
- pidx (log2 C_DDP bits, 0 for C_DDP=1): pixel index within head; increments per handshake, wraps C_DDP-1 -> 0.
- Outputs are a mux of head by pidx, from registers only; m_axis_tvalid = head valid.
- Handshake: while tvalid & ~tready, tdata/tuser/tlast/tvalid hold stable.
- Simultaneous word_done and arriving data: arriving word goes to next (or head if head/next both freed); no loss, no reorder.
- tuser/tlast carried verbatim; no frame-structure checking (except Configuration).

## Timing
- Reset: m_axis_tvalid 0, tdata 0, tuser 0, tlast 0, rd_en 0, pidx 0, buffer empty, rd_pending 0.
- Reset mid-word: buffered and pending words discarded; a read data arriving the cycle after reset is ignored.
- Latency: empty falls in cycle N, rd_en high in N, data captured end of N+1, m_axis_tvalid high in N+2.
- Throughput: FIFO non-empty and tready held 1 -> tvalid continuous, one pixel/clock, for every C_DDP including 1.
- Underflow: FIFO runs dry -> tvalid drops after last buffered pixel, no garbage pixel.

## Configuration
- FIFO2STREAM_SOF_SYNC_EN defined: two-state FSM SEARCH/RUN. Reset -> SEARCH. In SEARCH, m_axis_tvalid held 0; one pixel per clock is internally discarded (pidx advances, word_done as normal) until a pixel with tuser=1 is at head/pidx; that pixel is presented with tvalid=1 and FSM enters RUN. RUN is left only by reset.
- Undefined: no FSM; first pixel after reset is emitted regardless of tuser.

## Structure
- Shared package: word-width function (C_DDP*(C_PIXEL_WIDTH+2)), field offsets for tdata/tuser/tlast within a pixel slot, logb2 helper; common with the packer.
- One sub-module natural: fifo2stream_wordbuf (two-entry buffer, occ/rd_pending, rd_en logic); pixel mux and FSM in top.

## Test plan
- C_DDP=4, FIFO holds word pixels {0x11,0x22,0x33,0x44}, tuser on pixel 0, tready=1 -> tvalid from rd_en+2, tdata 0x11,0x22,0x33,0x44 on consecutive clocks, tuser only with 0x11.
- 8 words queued, tready=1 -> 32 back-to-back pixels, no tvalid gap; rd_en never high with empty=1.
- tready toggled 1/0 each cycle -> outputs stable during stalls, sequence intact, FIFO never popped beyond 2 words ahead.
- tlast on pixel 2 of word 3 -> m_axis_tlast high exactly on the 11th pixel (0-based 10).
- resetn low mid-word with rd_pending=1 -> next cycle all outputs at reset values; post-reset first pixel is pixel 0 of next FIFO word.
- SOF_SYNC_EN: first word tuser only on pixel 2 -> pixels 0,1 dropped; first tvalid carries pixel 2 with tuser=1; later words unfiltered.
